// File: rtl/selfcon_pkg.sv
// ============================================================================
// Module : selfcon_pkg
// Brief  : FSM state type and speed-to-delay constants for selfcon_scan_ctrl.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package selfcon_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CUT_RST   = 3'd1,
        WAIT_LOW  = 3'd2,
        WAIT_OVER = 3'd3,
        EVAL      = 3'd4,
        UPDATE    = 3'd5,
        DONE      = 3'd6
    } state_t;

    // Speed codes above the threshold use the high offset.
    localparam int c_spd_thresh = 20;
    localparam int c_ofs_hi     = 1000;
    localparam int c_ofs_lo     = 900;
    localparam int c_scale      = 10;

endpackage

`default_nettype wire

// File: rtl/selfcon_delay_conv.sv
// ============================================================================
// Module : selfcon_delay_conv
// Brief  : Combinational conversion of a captured speed code into ps delay.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module selfcon_delay_conv
    import selfcon_pkg::*;
#(
    parameter int SPEED_W = 10,
    parameter int DELAY_W = 14
) (
    input  logic [SPEED_W-1:0] speed,
    output logic [DELAY_W-1:0] delay_ps
);

    logic [DELAY_W-1:0] w_speed_ext;
    logic [DELAY_W-1:0] w_scaled;
    logic               w_hi_regime;

    assign w_speed_ext = DELAY_W'(speed);
    assign w_scaled    = w_speed_ext * DELAY_W'(c_scale);
    assign w_hi_regime = (speed > SPEED_W'(c_spd_thresh));
    assign delay_ps    = w_hi_regime ? (w_scaled + DELAY_W'(c_ofs_hi))
                                     : (w_scaled + DELAY_W'(c_ofs_lo));

endmodule

`default_nettype wire

// File: rtl/selfcon_scan_ctrl.sv
// ============================================================================
// Module : selfcon_scan_ctrl
// Brief  : Self-convergence controller driving ScanNum and CUT reset for BIST.
//          Optional watchdog enabled by defining SELFCON_WDOG_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module selfcon_scan_ctrl
    import selfcon_pkg::*;
#(
    parameter int SCAN_W     = 20,
    parameter int SPEED_W    = 10,
    parameter int DELAY_W    = 14,
    parameter int SCAN_START = 60,
    parameter int SCAN_BASE  = 10,
    parameter int EPS        = 10,
    parameter int K_TARGET   = 8,
    parameter int MAX_RUNS   = 32,
    parameter int RST_CYC    = 3,
    parameter int MULT_MAX   = 8,
    parameter int WDOG_CYC   = 500000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               go,
    input  logic               bist_over,
    input  logic [SPEED_W-1:0] speed,
    output logic [SCAN_W-1:0]  scan_num,
    output logic               bist_rst_n,
    output logic [DELAY_W-1:0] delay_ps,
    output logic [5:0]         run_cnt,
    output logic [3:0]         conv_cnt,
    output logic               busy,
    output logic               done,
    output logic               converged,
    output logic               timeout
);

    localparam int c_mult_lw = $clog2(MULT_MAX + 1);
    localparam int c_rst_w   = $clog2(RST_CYC + 1);
    localparam int c_sum_w   = SCAN_W + 1;
    localparam logic [SCAN_W:0] c_base = c_sum_w'(SCAN_BASE);

    state_t               r_state;
    state_t               w_state_next;
    logic [SCAN_W-1:0]    r_scan_num;
    logic                 r_bist_rst_n;
    logic [DELAY_W-1:0]   r_delay_lat;
    logic [DELAY_W-1:0]   r_delay_ps;
    logic [DELAY_W-1:0]   r_prev_delay;
    logic [5:0]           r_run_cnt;
    logic [3:0]           r_conv_cnt;
    logic [c_mult_lw-1:0] r_mult_log;
    logic [c_rst_w-1:0]   r_rst_cnt;
    logic                 r_converged;

    logic [DELAY_W-1:0]   w_delay_conv;
    logic [DELAY_W-1:0]   w_diff;
    logic                 w_step_conv;
    logic [SCAN_W:0]      w_incr;
    logic [SCAN_W:0]      w_scan_sum;
    logic [SCAN_W-1:0]    w_scan_sat;
    logic                 w_wdog_fire;
    logic                 w_busy;
    logic                 w_done;

    selfcon_delay_conv #(
        .SPEED_W (SPEED_W),
        .DELAY_W (DELAY_W)
    ) u_delay_conv (
        .speed    (speed),
        .delay_ps (w_delay_conv)
    );

    // Absolute difference, so a falling delay cannot wrap into a false result.
    assign w_diff      = (r_delay_lat >= r_prev_delay) ? (r_delay_lat - r_prev_delay)
                                                       : (r_prev_delay - r_delay_lat);
    assign w_step_conv = (r_run_cnt != 6'd0) && (w_diff <= DELAY_W'(EPS));

    // Multiplier is kept as a power-of-two exponent; increment = base << exp.
    assign w_incr      = c_base << r_mult_log;
    assign w_scan_sum  = {1'b0, r_scan_num} + w_incr;
    assign w_scan_sat  = w_scan_sum[SCAN_W] ? {SCAN_W{1'b1}} : w_scan_sum[SCAN_W-1:0];

    always_comb begin
        w_state_next = r_state;
        w_busy       = 1'b1;
        w_done       = 1'b0;
        case (r_state)
            IDLE: begin
                w_busy = 1'b0;
                if (go) w_state_next = CUT_RST;
            end
            DONE: begin
                w_busy = 1'b0;
                w_done = 1'b1;
                if (go) w_state_next = CUT_RST;
            end
            CUT_RST: begin
                if (r_rst_cnt == c_rst_w'(RST_CYC - 1)) w_state_next = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (w_wdog_fire)     w_state_next = DONE;
                else if (!bist_over) w_state_next = WAIT_OVER;
            end
            WAIT_OVER: begin
                if (w_wdog_fire)    w_state_next = DONE;
                else if (bist_over) w_state_next = EVAL;
            end
            EVAL: begin
                w_state_next = UPDATE;
            end
            UPDATE: begin
                if ((r_conv_cnt == 4'(K_TARGET)) || (r_run_cnt == 6'(MAX_RUNS)))
                    w_state_next = DONE;
                else
                    w_state_next = CUT_RST;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // CUT reset is registered from the next state: low exactly while in CUT_RST.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bist_rst_n <= 1'b1;
            r_rst_cnt    <= '0;
        end else begin
            r_bist_rst_n <= (w_state_next != CUT_RST);
            r_rst_cnt    <= (r_state == CUT_RST) ? (r_rst_cnt + 1'b1) : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan_num   <= SCAN_W'(SCAN_START);
            r_delay_lat  <= '0;
            r_delay_ps   <= '0;
            r_prev_delay <= '0;
            r_run_cnt    <= '0;
            r_conv_cnt   <= '0;
            r_mult_log   <= '0;
            r_converged  <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (go) begin
                        r_scan_num   <= SCAN_W'(SCAN_START);
                        r_prev_delay <= '0;
                        r_run_cnt    <= '0;
                        r_conv_cnt   <= '0;
                        r_mult_log   <= '0;
                        r_converged  <= 1'b0;
                    end
                end
                WAIT_OVER: begin
                    if (w_state_next == EVAL) r_delay_lat <= w_delay_conv;
                end
                EVAL: begin
                    r_delay_ps   <= r_delay_lat;
                    r_prev_delay <= r_delay_lat;
                    r_run_cnt    <= r_run_cnt + 6'd1;
                    if (w_step_conv) begin
                        r_conv_cnt <= r_conv_cnt + 4'd1;
                        if (r_mult_log < c_mult_lw'(MULT_MAX)) r_mult_log <= r_mult_log + 1'b1;
                    end
                end
                UPDATE: begin
                    r_scan_num <= w_scan_sat;
                    if (r_conv_cnt == 4'(K_TARGET)) r_converged <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef SELFCON_WDOG_EN
    localparam int c_wdog_w = $clog2(WDOG_CYC + 1);

    logic [c_wdog_w-1:0] r_wdog_cnt;
    logic                r_timeout;
    logic                w_in_wait;

    assign w_in_wait   = (r_state == WAIT_LOW) || (r_state == WAIT_OVER);
    assign w_wdog_fire = w_in_wait && (r_wdog_cnt == c_wdog_w'(WDOG_CYC - 1));

    // Counts consecutive cycles in one wait state; any state change clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdog_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_wdog_cnt <= (w_in_wait && (w_state_next == r_state)) ? (r_wdog_cnt + 1'b1) : '0;
            if (w_wdog_fire)
                r_timeout <= 1'b1;
            else if (((r_state == IDLE) || (r_state == DONE)) && go)
                r_timeout <= 1'b0;
        end
    end

    assign timeout = r_timeout;
`else
    // Without the watchdog the wait states never time out.
    assign w_wdog_fire = (WDOG_CYC < 0);
    assign timeout     = 1'b0;
`endif

    assign scan_num   = r_scan_num;
    assign bist_rst_n = r_bist_rst_n;
    assign delay_ps   = r_delay_ps;
    assign run_cnt    = r_run_cnt;
    assign conv_cnt   = r_conv_cnt;
    assign busy       = w_busy;
    assign done       = w_done;
    assign converged  = r_converged;

endmodule

`default_nettype wire

// File: tb/tb_selfcon_scan_ctrl.sv
// ============================================================================
// Module : tb_selfcon_scan_ctrl
// Brief  : Scoreboard bench for selfcon_scan_ctrl with a behavioural CUT.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_selfcon_scan_ctrl;

    localparam int WDOG_T = 200;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        go = 1'b0;
    logic        bist_over = 1'b0;
    logic [9:0]  speed = '0;
    logic [19:0] scan_num;
    logic        bist_rst_n;
    logic [13:0] delay_ps;
    logic [5:0]  run_cnt;
    logic [3:0]  conv_cnt;
    logic        busy, done, converged, timeout;

    selfcon_scan_ctrl #(.WDOG_CYC(WDOG_T)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .go         (go),
        .bist_over  (bist_over),
        .speed      (speed),
        .scan_num   (scan_num),
        .bist_rst_n (bist_rst_n),
        .delay_ps   (delay_ps),
        .run_cnt    (run_cnt),
        .conv_cnt   (conv_cnt),
        .busy       (busy),
        .done       (done),
        .converged  (converged),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct { int dly; int run; int conv; } run_exp_t;
    typedef struct { int scan; int conv_flag; int run; int conv; int tmo; } done_exp_t;

    run_exp_t  run_q[$];
    int        scan_q[$];
    done_exp_t done_q[$];

    // Reference model state for the current campaign
    int m_prev, m_mult, m_scan, m_run, m_conv;
    bit m_end;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int ref_delay(input int s);
        return (s > 20) ? (1000 + 10 * s) : (900 + 10 * s);
    endfunction

    task automatic model_start();
        m_prev = 0; m_mult = 1; m_scan = 60; m_run = 0; m_conv = 0; m_end = 0;
        scan_q.push_back(60);
    endtask

    task automatic model_run(input int s);
        int d, diff;
        d    = ref_delay(s);
        diff = (d > m_prev) ? d - m_prev : m_prev - d;
        if (m_run > 0 && diff <= 10) begin
            m_mult = (m_mult * 2 > 256) ? 256 : m_mult * 2;
            m_conv++;
        end
        m_run++;
        m_prev = d;
        run_q.push_back('{d, m_run, m_conv});
        m_scan = (m_scan + m_mult * 10 > 1048575) ? 1048575 : m_scan + m_mult * 10;
        if (m_conv == 8) begin
            m_end = 1;
            done_q.push_back('{m_scan, 1, m_run, m_conv, 0});
        end else if (m_run == 32) begin
            m_end = 1;
            done_q.push_back('{m_scan, 0, m_run, m_conv, 0});
        end else begin
            scan_q.push_back(m_scan);
        end
    endtask

    // Monitor: compares whenever the DUT presents a new result
    int        p_run = 0;
    logic      p_rst = 1'b1;
    logic      p_done = 1'b0;
    run_exp_t  me;
    done_exp_t md;
    int        ms;

    always @(negedge clk) begin
        if (!rst_n) begin
            p_run = 0; p_rst = 1'b1; p_done = 1'b0;
        end else begin
            if (int'(run_cnt) != p_run && run_cnt != 6'd0) begin
                if (run_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL run_result: unexpected run_cnt %0d, expected no result", run_cnt);
                end else begin
                    me = run_q.pop_front();
                    check("delay_ps", int'(delay_ps), me.dly);
                    check("run_cnt", int'(run_cnt), me.run);
                    check("conv_cnt", int'(conv_cnt), me.conv);
                end
            end
            if (p_rst && !bist_rst_n) begin
                if (scan_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL cut_reset: unexpected CUT reset, scan_num %0d, expected none", scan_num);
                end else begin
                    ms = scan_q.pop_front();
                    check("scan_num_at_run", int'(scan_num), ms);
                end
            end
            if (!p_done && done) begin
                if (done_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL done: unexpected done, run_cnt %0d, expected busy", run_cnt);
                end else begin
                    md = done_q.pop_front();
                    check("final_scan_num", int'(scan_num), md.scan);
                    check("final_converged", int'(converged), md.conv_flag);
                    check("final_run_cnt", int'(run_cnt), md.run);
                    check("final_conv_cnt", int'(conv_cnt), md.conv);
                    check("final_timeout", int'(timeout), md.tmo);
                    check("final_busy", int'(busy), 0);
                end
            end
            p_run  = int'(run_cnt);
            p_rst  = bist_rst_n;
            p_done = done;
        end
    end

    function automatic int pick(input int mode, input int idx, input int base);
        int v;
        case (mode)
            0: return 25;
            1: return (idx == 0) ? 21 : ((idx == 1) ? 20 : 19);
            2: return (idx % 2) ? 40 : 25;
            default: begin
                if ($urandom_range(0, 5) == 0) return int'($urandom_range(0, 1023));
                v = base + int'($urandom_range(0, 2)) - 1;
                if (v < 0) v = 0;
                if (v > 1023) v = 1023;
                return v;
            end
        endcase
    endfunction

    task automatic start_campaign();
        model_start();
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        check("go_to_cut_reset", int'(bist_rst_n), 0);
    endtask

    // Behavioural CUT for one run; stale mode holds an old 'over' through reset.
    task automatic do_run(input int s, input bit stale, input bit poke_go);
        int n;
        n = 0;
        while (bist_rst_n !== 1'b0 && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) begin
            checks++; errors++;
            $display("FAIL run_start: bist_rst_n stayed %b, expected 0 within 100 cycles", bist_rst_n);
            return;
        end
        if (stale) speed = 10'($urandom_range(0, 1023));
        else bist_over = 1'b0;
        n = 0;
        while (bist_rst_n === 1'b0 && n < 100) begin @(negedge clk); n++; end
        check("cut_reset_len", n, 3);
        if (stale) begin
            repeat ($urandom_range(1, 3)) @(negedge clk);
            bist_over = 1'b0;
        end
        repeat ($urandom_range(1, 4)) @(negedge clk);
        speed = 10'(s);
        bist_over = 1'b1;
        go = poke_go;
        model_run(s);
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic run_campaign(input int mode, input int base);
        int idx, n;
        start_campaign();
        idx = 0;
        while (!m_end && idx < 40) begin
            do_run(pick(mode, idx, base), ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0));
            idx++;
        end
        n = 0;
        while (!done && n < 50) begin @(negedge clk); n++; end
        if (!done) begin
            checks++; errors++;
            $display("FAIL campaign_done: done %b, expected 1 within 50 cycles", done);
        end
        repeat (4) @(negedge clk);
        check("done_hold", int'(done), 1);
    endtask

    task automatic check_reset_values();
        check("rst_scan_num", int'(scan_num), 60);
        check("rst_bist_rst_n", int'(bist_rst_n), 1);
        check("rst_delay_ps", int'(delay_ps), 0);
        check("rst_run_cnt", int'(run_cnt), 0);
        check("rst_conv_cnt", int'(conv_cnt), 0);
        check("rst_status", int'({busy, done, converged, timeout}), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation still running, expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        #2 rst_n = 1'b0;
        #1 check_reset_values();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_campaign(0, 0);
        check("const25_scan", int'(scan_num), 5170);
        check("const25_converged", int'(converged), 1);
        run_campaign(1, 0);
        run_campaign(2, 0);
        check("alternate_scan", int'(scan_num), 380);
        check("alternate_run_cnt", int'(run_cnt), 32);
        for (int c = 0; c < 5; c++)
            run_campaign(3, (c % 2) ? int'($urandom_range(0, 1023)) : int'($urandom_range(18, 23)));
        check("queues_drained", run_q.size() + scan_q.size() + done_q.size(), 0);

        // Reset while waiting for 'over' in the third run
        start_campaign();
        do_run(30, 1'b0, 1'b0);
        do_run(31, 1'b0, 1'b0);
        n = 0;
        while (bist_rst_n !== 1'b0 && n < 100) begin @(negedge clk); n++; end
        bist_over = 1'b0;
        n = 0;
        while (bist_rst_n === 1'b0 && n < 100) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        check("busy_wait_over", int'(busy), 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_values();
        @(negedge clk);
        check_reset_values();
        rst_n = 1'b1;
        run_q.delete(); scan_q.delete(); done_q.delete();
        @(negedge clk);
        run_campaign(1, 0);

        // 'over' stuck low
        start_campaign();
        bist_over = 1'b0;
        n = 0;
        while (bist_rst_n === 1'b0 && n < 100) begin @(negedge clk); n++; end
`ifdef SELFCON_WDOG_EN
        done_q.push_back('{60, 0, 0, 0, 1});
        n = 0;
        while (!done && n < WDOG_T + 50) begin @(negedge clk); n++; end
        check("wdog_window", int'(n >= WDOG_T && n <= WDOG_T + 5), 1);
        check("wdog_timeout", int'(timeout), 1);
`else
        repeat (WDOG_T + 50) @(negedge clk);
        check("stuck_busy", int'(busy), 1);
        check("stuck_done", int'(done), 0);
        check("stuck_timeout", int'(timeout), 0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        scan_q.delete();
`endif
        @(negedge clk);
        check("queues_empty_end", run_q.size() + scan_q.size() + done_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
